fb_arb_ctrl: RTL and testbench
==============================

FB_ARB_CTRL -- requirements
Module: fb_arb_ctrl

Interface
REQ-001 SHALL provide parameter WR_BURST_SIZE, default 16, max write beats per burst (1..31).
REQ-002 SHALL provide parameter RD_BURST_SIZE, default 16, max read beats per burst (1..31).
REQ-003 SHALL provide parameter NUM_FB, default 3, number of frame buffers (2..4).
REQ-004 SHALL provide parameter DROP_MODE, default 1; 1 = overwrite newest unread frame when no buffer is free, 0 = stall writer.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 SHALL have these ports:
- clk  in  1  sole clock.
- reset  in  1  async active-high reset.
- init_done  in  1  system init complete, level.
- wr_avail  in  1  camera FIFO not empty.
- wr_ready  in  1  memory accepts write beat.
- rd_space  in  1  output FIFO not full.
- rd_ready  in  1  memory accepts read request.
- frame_wr_done  in  1  one-cycle pulse, write frame complete.
- frame_rd_done  in  1  one-cycle pulse, read frame complete.
- wr_en  out  1  active-high write beat.
- rd_en  out  1  active-high read beat.
- wr_fb  out  2  buffer index being written.
- rd_fb  out  2  buffer index being read.
- wr_stall  out  1  writer has no free buffer (DROP_MODE=0 only).
- frame_num  out  32  frames delivered to reader.
- drop_cnt  out  16  frames overwritten.
- repeat_cnt  out  16  frames repeated.

Function
REQ-007 SHALL implement FSM states S_IDLE, S_WR_BRST, S_RD_BRST.
REQ-008 S_IDLE SHALL go to S_WR_BRST on the first clock with init_done=1.
REQ-009 wr_en SHALL be combinational: (state==S_WR_BRST) & wr_avail & wr_ready & ~wr_stall.
REQ-010 rd_en SHALL be combinational: (state==S_RD_BRST) & rd_space & rd_ready.
REQ-011 A 5-bit beat counter SHALL increment on each wr_en or rd_en beat and clear on every state change.
REQ-012 S_WR_BRST SHALL exit after the WR_BURST_SIZE-th beat, or in any cycle with wr_avail=0 or wr_stall=1.
REQ-013 On S_WR_BRST exit, next state SHALL be S_RD_BRST if rd_space=1, else S_WR_BRST with the counter cleared.
REQ-014 S_RD_BRST SHALL exit after the RD_BURST_SIZE-th beat, or in any cycle with rd_space=0.
REQ-015 On S_RD_BRST exit, next state SHALL be S_WR_BRST if wr_avail & ~wr_stall, else S_RD_BRST with the counter cleared.
REQ-016 An internal latest index plus latest_valid flag SHALL track the newest completed, unread frame.
REQ-017 On frame_wr_done: latest<=wr_fb, latest_valid<=1, and wr_fb<=lowest index not equal to rd_fb and not equal to new latest.
REQ-018 If REQ-017 finds no free index and DROP_MODE=1, wr_fb SHALL be set to the old latest buffer, latest_valid SHALL stay 1, and drop_cnt SHALL increment, saturating at 16'hFFFF; this drops the older of the two unread frames.
REQ-019 If no free index exists and DROP_MODE=0, wr_fb SHALL hold and wr_stall<=1 until the next frame_rd_done frees a buffer.
REQ-020 On frame_rd_done with latest_valid=1: rd_fb<=latest, latest_valid<=0, and frame_num SHALL increment (32-bit wrap).
REQ-021 On frame_rd_done with latest_valid=0: rd_fb SHALL hold, repeat_cnt SHALL increment (saturating), and frame_num SHALL increment.
REQ-022 Simultaneous frame_wr_done and frame_rd_done SHALL be handled in this order within one cycle:
- the write completes first;
- the reader takes the just-written buffer (rd_fb<=old wr_fb);
- the writer picks the lowest free index excluding the new rd_fb;
- wr_stall SHALL clear if set.
REQ-023 wr_fb and rd_fb SHALL never be equal in any cycle after reset.
REQ-024 Pulses arriving in S_IDLE SHALL be ignored.

Reset
REQ-025 Asserting reset SHALL immediately force:
- state=S_IDLE, wr_en=0, rd_en=0;
- wr_fb=1, rd_fb=0;
- latest=0, latest_valid=0, wr_stall=0;
- frame_num=0, drop_cnt=0, repeat_cnt=0, beat counter=0.
REQ-026 Reset asserted mid-burst SHALL drop wr_en/rd_en in the same cycle, with no partial-burst state retained after release.

Verification
REQ-027 Bench SHALL cover directed scenarios:
- Burst alternation: init_done=1, all inputs high, defaults -> 16 wr_en beats, then 16 rd_en beats, alternating, no gap cycles.
- Early exit: wr_avail drops at beat 5 -> S_RD_BRST next cycle, counter=0.
- Triple rotation: NUM_FB=3, frame_wr_done twice, no reads -> wr_fb 1->2->1; on the second pulse latest moves to 2; drop_cnt=0.
- Drop: NUM_FB=2, DROP_MODE=1, two frame_wr_done, no read -> drop_cnt=1, wr_fb!=rd_fb throughout.
- Stall: NUM_FB=2, DROP_MODE=0, frame_wr_done -> wr_stall=1, wr_en=0; frame_rd_done -> rd_fb=1, wr_fb=0, wr_stall=0.
- Repeat/simultaneous: frame_rd_done with latest_valid=0 -> repeat_cnt=1, frame_num=1; then simultaneous pulses -> rd_fb=old wr_fb, frame_num=2.

Source files
------------

// File: rtl/fb_arb_ctrl.sv
// Frame-buffer arbiter: alternates write and read bursts to shared memory and
// rotates the write/read frame-buffer indices as frames complete.
module fb_arb_ctrl #(
  parameter int WR_BURST_SIZE = 16,
  parameter int RD_BURST_SIZE = 16,
  parameter int NUM_FB        = 3,
  parameter int DROP_MODE     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_done,
  input  logic        wr_avail,
  input  logic        wr_ready,
  input  logic        rd_space,
  input  logic        rd_ready,
  input  logic        frame_wr_done,
  input  logic        frame_rd_done,
  output logic        wr_en,
  output logic        rd_en,
  output logic [1:0]  wr_fb,
  output logic [1:0]  rd_fb,
  output logic        wr_stall,
  output logic [31:0] frame_num,
  output logic [15:0] drop_cnt,
  output logic [15:0] repeat_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WR_BRST, S_RD_BRST} state_t;

  localparam logic [4:0] WR_LAST = 5'(WR_BURST_SIZE - 1);
  localparam logic [4:0] RD_LAST = 5'(RD_BURST_SIZE - 1);

  state_t     state;
  state_t     state_nxt;
  logic       burst_exit;
  logic [4:0] beat_cnt;
  logic [1:0] latest;
  logic       latest_valid;
  logic       wr_free_ok;
  logic [1:0] wr_free_idx;
  logic [1:0] rd_free_idx;
  logic [1:0] sim_free_idx;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Lowest buffer index that is neither ex_a nor ex_b.
  function automatic logic [1:0] free_idx(input logic [1:0] ex_a, input logic [1:0] ex_b);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_FB - 1; i >= 0; i--) begin
      if (2'(i) != ex_a && 2'(i) != ex_b) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic free_ok(input logic [1:0] ex_a, input logic [1:0] ex_b);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < NUM_FB; i++) begin
      if (2'(i) != ex_a && 2'(i) != ex_b) ok = 1'b1;
    end
    return ok;
  endfunction

  assign wr_en = (state == S_WR_BRST) & wr_avail & wr_ready & ~wr_stall;
  assign rd_en = (state == S_RD_BRST) & rd_space & rd_ready;

  assign wr_free_ok   = free_ok(rd_fb, wr_fb);
  assign wr_free_idx  = free_idx(rd_fb, wr_fb);
  assign rd_free_idx  = free_idx(latest, latest);
  assign sim_free_idx = free_idx(wr_fb, wr_fb);

  always_comb begin
    state_nxt  = state;
    burst_exit = 1'b0;
    case (state)
      S_IDLE: begin
        if (init_done) state_nxt = S_WR_BRST;
      end
      S_WR_BRST: begin
        burst_exit = (wr_en && beat_cnt == WR_LAST) || !wr_avail || wr_stall;
        if (burst_exit) state_nxt = rd_space ? S_RD_BRST : S_WR_BRST;
      end
      S_RD_BRST: begin
        burst_exit = (rd_en && beat_cnt == RD_LAST) || !rd_space;
        if (burst_exit) state_nxt = (wr_avail && !wr_stall) ? S_WR_BRST : S_RD_BRST;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      beat_cnt <= 5'd0;
    end else begin
      state <= state_nxt;
      if (burst_exit || state_nxt != state) beat_cnt <= 5'd0;
      else if (wr_en || rd_en)              beat_cnt <= beat_cnt + 5'd1;
    end
  end

  // Buffer rotation; a simultaneous write+read completion hands the fresh frame
  // straight to the reader, and a stalled writer ignores its own done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_fb        <= 2'd1;
      rd_fb        <= 2'd0;
      latest       <= 2'd0;
      latest_valid <= 1'b0;
      wr_stall     <= 1'b0;
      frame_num    <= 32'd0;
      drop_cnt     <= 16'd0;
      repeat_cnt   <= 16'd0;
    end else if (state != S_IDLE) begin
      if (frame_wr_done && frame_rd_done) begin
        latest       <= wr_fb;
        latest_valid <= 1'b0;
        rd_fb        <= wr_fb;
        wr_fb        <= sim_free_idx;
        wr_stall     <= 1'b0;
        frame_num    <= frame_num + 32'd1;
      end else if (frame_wr_done && !wr_stall) begin
        latest       <= wr_fb;
        latest_valid <= 1'b1;
        if (wr_free_ok) begin
          wr_fb <= wr_free_idx;
        end else if (DROP_MODE != 0) begin
          // Only an already-pending frame counts as dropped; with none pending
          // the writer simply keeps its current buffer.
          if (latest_valid) begin
            wr_fb    <= latest;
            drop_cnt <= sat_inc16(drop_cnt);
          end
        end else begin
          wr_stall <= 1'b1;
        end
      end else if (frame_rd_done) begin
        frame_num <= frame_num + 32'd1;
        if (latest_valid) begin
          rd_fb        <= latest;
          latest_valid <= 1'b0;
          if (wr_stall || latest == wr_fb) begin
            wr_fb    <= rd_free_idx;
            wr_stall <= 1'b0;
          end
        end else begin
          repeat_cnt <= sat_inc16(repeat_cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_arb_ctrl.sv
// Directed bench for fb_arb_ctrl: vector table on the default build plus
// hand sequences for burst timing, drop and stall variants.
module tb_fb_arb_ctrl;

  logic clk;
  logic reset;
  logic init_done, wr_avail, wr_ready, rd_space, rd_ready;
  logic frame_wr_done, frame_rd_done;

  logic        d_wr_en, d_rd_en, d_wr_stall;
  logic [1:0]  d_wr_fb, d_rd_fb;
  logic [31:0] d_frame_num;
  logic [15:0] d_drop_cnt, d_repeat_cnt;

  logic        p_wr_en, p_rd_en, p_wr_stall;
  logic [1:0]  p_wr_fb, p_rd_fb;
  logic [31:0] p_frame_num;
  logic [15:0] p_drop_cnt, p_repeat_cnt;

  logic        s_wr_en, s_rd_en, s_wr_stall;
  logic [1:0]  s_wr_fb, s_rd_fb;
  logic [31:0] s_frame_num;
  logic [15:0] s_drop_cnt, s_repeat_cnt;

  int n_chk = 0;
  int n_err = 0;

  fb_arb_ctrl u_dflt (
    .clk(clk), .reset(reset), .init_done(init_done), .wr_avail(wr_avail),
    .wr_ready(wr_ready), .rd_space(rd_space), .rd_ready(rd_ready),
    .frame_wr_done(frame_wr_done), .frame_rd_done(frame_rd_done),
    .wr_en(d_wr_en), .rd_en(d_rd_en), .wr_fb(d_wr_fb), .rd_fb(d_rd_fb),
    .wr_stall(d_wr_stall), .frame_num(d_frame_num), .drop_cnt(d_drop_cnt),
    .repeat_cnt(d_repeat_cnt)
  );

  fb_arb_ctrl #(.NUM_FB(2), .DROP_MODE(1)) u_drop (
    .clk(clk), .reset(reset), .init_done(init_done), .wr_avail(wr_avail),
    .wr_ready(wr_ready), .rd_space(rd_space), .rd_ready(rd_ready),
    .frame_wr_done(frame_wr_done), .frame_rd_done(frame_rd_done),
    .wr_en(p_wr_en), .rd_en(p_rd_en), .wr_fb(p_wr_fb), .rd_fb(p_rd_fb),
    .wr_stall(p_wr_stall), .frame_num(p_frame_num), .drop_cnt(p_drop_cnt),
    .repeat_cnt(p_repeat_cnt)
  );

  fb_arb_ctrl #(.NUM_FB(2), .DROP_MODE(0)) u_stall (
    .clk(clk), .reset(reset), .init_done(init_done), .wr_avail(wr_avail),
    .wr_ready(wr_ready), .rd_space(rd_space), .rd_ready(rd_ready),
    .frame_wr_done(frame_wr_done), .frame_rd_done(frame_rd_done),
    .wr_en(s_wr_en), .rd_en(s_rd_en), .wr_fb(s_wr_fb), .rd_fb(s_rd_fb),
    .wr_stall(s_wr_stall), .frame_num(s_frame_num), .drop_cnt(s_drop_cnt),
    .repeat_cnt(s_repeat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input bits: {rst, init_done, wr_avail, wr_ready, rd_space, rd_ready, wr_done, rd_done}
  typedef struct {
    logic [7:0]  in;
    logic [1:0]  en;
    logic [1:0]  wfb;
    logic [1:0]  rfb;
    logic [31:0] fn;
    logic [15:0] drop;
    logic [15:0] rep;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ne(input string name, input logic [1:0] a, input logic [1:0] b);
    n_chk++;
    if (a === b || $isunknown(a) || $isunknown(b)) begin
      n_err++;
      $display("FAIL %s: wr_fb %0h rd_fb %0h must differ", name, a, b);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic wa, input logic wrdy, input logic rs, input logic rrdy);
    reset = 1'b1;
    init_done = 1'b1;
    wr_avail = wa; wr_ready = wrdy; rd_space = rs; rd_ready = rrdy;
    frame_wr_done = 1'b0; frame_rd_done = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk_ne("fb_distinct_dflt", d_wr_fb, d_rd_fb);
      chk_ne("fb_distinct_drop", p_wr_fb, p_rd_fb);
      chk_ne("fb_distinct_stall", s_wr_fb, s_rd_fb);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    init_done = 1'b0; wr_avail = 1'b0; wr_ready = 1'b0; rd_space = 1'b0; rd_ready = 1'b0;
    frame_wr_done = 1'b0; frame_rd_done = 1'b0;

    vt[0]  = '{8'b11111100, 2'b00, 2'd1, 2'd0, 32'd0, 16'd0, 16'd0};
    vt[1]  = '{8'b00000010, 2'b00, 2'd1, 2'd0, 32'd0, 16'd0, 16'd0};
    vt[2]  = '{8'b00000001, 2'b00, 2'd1, 2'd0, 32'd0, 16'd0, 16'd0};
    vt[3]  = '{8'b01000000, 2'b00, 2'd1, 2'd0, 32'd0, 16'd0, 16'd0};
    vt[4]  = '{8'b01000001, 2'b00, 2'd1, 2'd0, 32'd0, 16'd0, 16'd0};
    vt[5]  = '{8'b01000011, 2'b00, 2'd1, 2'd0, 32'd1, 16'd0, 16'd1};
    vt[6]  = '{8'b01000000, 2'b00, 2'd0, 2'd1, 32'd2, 16'd0, 16'd1};
    vt[7]  = '{8'b10000000, 2'b00, 2'd1, 2'd0, 32'd0, 16'd0, 16'd0};
    vt[8]  = '{8'b01000000, 2'b00, 2'd1, 2'd0, 32'd0, 16'd0, 16'd0};
    vt[9]  = '{8'b01000010, 2'b00, 2'd1, 2'd0, 32'd0, 16'd0, 16'd0};
    vt[10] = '{8'b01000010, 2'b00, 2'd2, 2'd0, 32'd0, 16'd0, 16'd0};
    vt[11] = '{8'b01000000, 2'b00, 2'd1, 2'd0, 32'd0, 16'd0, 16'd0};
    vt[12] = '{8'b01000001, 2'b00, 2'd1, 2'd0, 32'd0, 16'd0, 16'd0};
    vt[13] = '{8'b01000000, 2'b00, 2'd1, 2'd2, 32'd1, 16'd0, 16'd0};
    vt[14] = '{8'b01110000, 2'b10, 2'd1, 2'd2, 32'd1, 16'd0, 16'd0};
    vt[15] = '{8'b01100000, 2'b00, 2'd1, 2'd2, 32'd1, 16'd0, 16'd0};
    vt[16] = '{8'b01111100, 2'b10, 2'd1, 2'd2, 32'd1, 16'd0, 16'd0};

    cyc();
    for (int i = 0; i < NV; i++) begin
      {reset, init_done, wr_avail, wr_ready, rd_space, rd_ready, frame_wr_done, frame_rd_done} = vt[i].in;
      #3;
      chk($sformatf("v%0d_wr_en", i),  32'(d_wr_en),      32'(vt[i].en[1]));
      chk($sformatf("v%0d_rd_en", i),  32'(d_rd_en),      32'(vt[i].en[0]));
      chk($sformatf("v%0d_wr_fb", i),  32'(d_wr_fb),      32'(vt[i].wfb));
      chk($sformatf("v%0d_rd_fb", i),  32'(d_rd_fb),      32'(vt[i].rfb));
      chk($sformatf("v%0d_fnum", i),   d_frame_num,       vt[i].fn);
      chk($sformatf("v%0d_drop", i),   32'(d_drop_cnt),   32'(vt[i].drop));
      chk($sformatf("v%0d_repeat", i), 32'(d_repeat_cnt), 32'(vt[i].rep));
      chk($sformatf("v%0d_stall", i),  32'(d_wr_stall),   32'd0);
      cyc();
    end

    // Burst alternation with everything ready: 16 writes, 16 reads, 16 writes.
    start_run(1'b1, 1'b1, 1'b1, 1'b1);
    #3;
    chk("alt_idle_wr_en", 32'(d_wr_en), 32'd0);
    cyc();
    for (int k = 0; k < 48; k++) begin
      #3;
      chk($sformatf("alt_c%0d_wr_en", k), 32'(d_wr_en), 32'((k / 16) % 2 == 0));
      chk($sformatf("alt_c%0d_rd_en", k), 32'(d_rd_en), 32'((k / 16) % 2 == 1));
      cyc();
    end

    // Reset mid read burst drops enables at once; a fresh burst starts from zero.
    repeat (4) cyc();
    #1;
    chk("midrst_pre_rd_en", 32'(d_rd_en), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_rd_en", 32'(d_rd_en), 32'd0);
    chk("midrst_wr_en", 32'(d_wr_en), 32'd0);
    cyc();
    reset = 1'b0;
    #3;
    chk("midrst_idle_wr_en", 32'(d_wr_en), 32'd0);
    cyc();
    for (int k = 0; k < 17; k++) begin
      #3;
      chk($sformatf("midrst_c%0d_wr_en", k), 32'(d_wr_en), 32'(k < 16));
      chk($sformatf("midrst_c%0d_rd_en", k), 32'(d_rd_en), 32'(k == 16));
      cyc();
    end

    // Early exit: wr_avail drops after 5 beats; a full 16-beat read burst follows.
    start_run(1'b1, 1'b1, 1'b1, 1'b1);
    cyc();
    repeat (5) cyc();
    wr_avail = 1'b0;
    #3;
    chk("early_exit_wr_en", 32'(d_wr_en), 32'd0);
    chk("early_exit_rd_en", 32'(d_rd_en), 32'd0);
    cyc();
    wr_avail = 1'b1;
    for (int k = 0; k < 17; k++) begin
      #3;
      chk($sformatf("early_c%0d_rd_en", k), 32'(d_rd_en), 32'(k < 16));
      chk($sformatf("early_c%0d_wr_en", k), 32'(d_wr_en), 32'(k == 16));
      cyc();
    end

    // Drop variant: second completed frame with no read overwrites the pending one.
    start_run(1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    frame_wr_done = 1'b1;
    cyc();
    frame_wr_done = 1'b0;
    #3;
    chk("drop1_cnt", 32'(p_drop_cnt), 32'd0);
    chk("drop1_wr_fb", 32'(p_wr_fb), 32'd1);
    chk("drop1_rd_fb", 32'(p_rd_fb), 32'd0);
    frame_wr_done = 1'b1;
    cyc();
    frame_wr_done = 1'b0;
    #3;
    chk("drop2_cnt", 32'(p_drop_cnt), 32'd1);
    chk("drop2_wr_fb", 32'(p_wr_fb), 32'd1);
    chk("drop2_rd_fb", 32'(p_rd_fb), 32'd0);
    frame_rd_done = 1'b1;
    cyc();
    frame_rd_done = 1'b0;
    #3;
    chk("drop_rd_rd_fb", 32'(p_rd_fb), 32'd1);
    chk("drop_rd_wr_fb", 32'(p_wr_fb), 32'd0);
    chk("drop_rd_fnum", p_frame_num, 32'd1);
    chk("drop_rd_repeat", 32'(p_repeat_cnt), 32'd0);

    // Stall variant: writer blocks until the reader frees a buffer.
    start_run(1'b1, 1'b1, 1'b0, 1'b0);
    cyc();
    #3;
    chk("stall_pre_wr_en", 32'(s_wr_en), 32'd1);
    frame_wr_done = 1'b1;
    cyc();
    frame_wr_done = 1'b0;
    #3;
    chk("stall_set", 32'(s_wr_stall), 32'd1);
    chk("stall_wr_en", 32'(s_wr_en), 32'd0);
    chk("stall_wr_fb", 32'(s_wr_fb), 32'd1);
    chk("stall_dflt_clear", 32'(d_wr_stall), 32'd0);
    cyc();
    #3;
    chk("stall_hold", 32'(s_wr_stall), 32'd1);
    frame_rd_done = 1'b1;
    cyc();
    frame_rd_done = 1'b0;
    #3;
    chk("stall_rel_rd_fb", 32'(s_rd_fb), 32'd1);
    chk("stall_rel_wr_fb", 32'(s_wr_fb), 32'd0);
    chk("stall_rel_clear", 32'(s_wr_stall), 32'd0);
    chk("stall_rel_wr_en", 32'(s_wr_en), 32'd1);
    chk("stall_rel_fnum", s_frame_num, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
